block_decrypt: RTL and testbench
================================

BLOCK_DECRYPT -- requirements
Module: block_decrypt

Interface
REQ-001 SHALL have one clock and reset: clk input 1 (all flops on rising edge); rst_n input 1, asynchronous, active-low.
REQ-002 SHALL have in_valid input 1: ciphertext block offered.
REQ-003 SHALL have in_ready output 1: block accepts a new ciphertext.
REQ-004 SHALL have in_data input 64: ciphertext block; byte W[j] = in_data[8j+7:8j].
REQ-005 SHALL have kk input 448: expanded round keys; kk[i] = kk[8i+7:8i] for i=0..55; held stable by the source from acceptance until output handshake.
REQ-006 SHALL have out_valid output 1: plaintext block available.
REQ-007 SHALL have out_ready input 1: sink accepts plaintext.
REQ-008 SHALL have out_data output 64: plaintext block, same byte order as in_data.

Function
REQ-009 SHALL use three states: IDLE, RUN, DONE.
REQ-010 SHALL set in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-011 SHALL, in IDLE with in_valid=1, load W from in_data, set round counter r=55 and go to RUN on the same edge.
REQ-012 SHALL, in RUN, execute one round per clock: S=sbox(kk[r]^W[6]); L=W[7]^S; W7<=W6; W6<=W5^perm(S); W5<=W4; W4<=W3^L; W3<=W2^L; W2<=W1^L; W1<=W0; W0<=L.
REQ-013 SHALL define perm as a fixed bit permutation: out[1]=in[0], out[7]=in[1], out[5]=in[2], out[4]=in[3], out[2]=in[4], out[3]=in[5], out[0]=in[6], out[6]=in[7].
REQ-014 SHALL decrement r each round; the round executed with r=0 moves to DONE (no wrap to 63).
REQ-015 SHALL have fixed latency: acceptance edge E0, rounds on E1..E56, out_valid=1 after E56.
REQ-016 SHALL drive out_data directly from W (registered); it holds stable while out_valid=1 and out_ready=0.
REQ-017 SHALL, in DONE with out_ready=1, return to IDLE on that edge; the next block can be accepted on the following edge (throughput one block per 58 cycles minimum).
REQ-018 SHALL ignore in_valid outside IDLE and out_ready outside DONE.
REQ-019 SHALL be combinational only from kk, W and r to the next W; no combinational path from in_valid to in_ready, or from out_ready to out_valid.

Reset
REQ-020 SHALL, on rst_n=0 at any time (including mid-RUN or in DONE), immediately set state=IDLE, r=0, W=0, in_ready=1, out_valid=0, out_data=0; the aborted block is discarded.
REQ-021 SHALL leave IDLE no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-022 SHALL place in the shared CSA package: the state enum, the constant CSA_ROUNDS=56, the perm function, and the byte-slice helper for kk/W.
REQ-023 SHALL instantiate exactly one block_sbox sub-module (input kk[r]^W[6], output S); no other sub-module.
REQ-024 SHALL hold the round counter in 6 bits.

Verification
REQ-025 SHALL cover latency: kk=all 0x00, in_data=0, out_ready=1 -> out_valid rises exactly 56 edges after acceptance; out_data matches the C reference model.
REQ-026 SHALL cover a known-answer test: kk from the reference key schedule of key 0x0123456789ABCDEF, in_data=0xFEDCBA9876543210 -> out_data equals the model value; in_ready=0 for the whole run.
REQ-027 SHALL cover backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid and out_data stable; in_valid=1 is not accepted; a single out_ready pulse -> IDLE next edge.
REQ-028 SHALL cover reset mid-operation: rst_n=0 at round 30 -> outputs zero/in_ready=1 asynchronously; the next block decrypts correctly without leftover state.
REQ-029 SHALL cover back-to-back operation: in_valid and out_ready held 1 for three blocks -> acceptances spaced exactly 58 cycles apart; all three outputs match the model.

Source files
------------

// File: rtl/block_decrypt_pkg.sv
// Shared definitions for the CSA block decipher: FSM states, round count,
// the fixed bit permutation applied to the S-box output, and a byte-slice helper.
package block_decrypt_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    localparam int unsigned CSA_ROUNDS = 56;

    // Fixed bit permutation: in[0]->out[1], in[1]->out[7], in[2]->out[5], in[3]->out[4],
    // in[4]->out[2], in[5]->out[3], in[6]->out[0], in[7]->out[6].
    function automatic logic [7:0] csa_perm(input logic [7:0] x);
        logic [7:0] y;
        y[1] = x[0];
        y[7] = x[1];
        y[5] = x[2];
        y[4] = x[3];
        y[2] = x[4];
        y[3] = x[5];
        y[0] = x[6];
        y[6] = x[7];
        return y;
    endfunction

    // Byte i of a little-endian byte vector; narrower vectors (W) are zero-extended.
    function automatic logic [7:0] csa_byte(input logic [447:0] v, input logic [5:0] idx);
        return v[8*int'(idx) +: 8];
    endfunction

endpackage

// File: rtl/block_sbox.sv
// CSA block-cipher S-box: pure combinational 8-bit lookup.
module block_sbox (
    input  logic [7:0] idx,
    output logic [7:0] s
);

    localparam logic [7:0] SBOX [256] = '{
        8'h3a, 8'hea, 8'h68, 8'hfe, 8'h33, 8'he9, 8'h88, 8'h1a,
        8'h83, 8'hcf, 8'he1, 8'h7f, 8'hba, 8'he2, 8'h38, 8'h12,
        8'he8, 8'h27, 8'h61, 8'h95, 8'h0c, 8'h36, 8'he5, 8'h70,
        8'ha2, 8'h06, 8'h82, 8'h7c, 8'h17, 8'ha3, 8'h26, 8'h49,
        8'hbe, 8'h7a, 8'h6d, 8'h47, 8'hc1, 8'h51, 8'h8f, 8'hf3,
        8'hcc, 8'h5b, 8'h67, 8'hbd, 8'hcd, 8'h18, 8'h08, 8'hc9,
        8'hff, 8'h69, 8'hef, 8'h03, 8'h4e, 8'h48, 8'h4a, 8'h84,
        8'h3f, 8'hb4, 8'h10, 8'h04, 8'hdc, 8'hf5, 8'h5c, 8'hc6,
        8'h16, 8'hab, 8'hac, 8'h4c, 8'hf1, 8'h6a, 8'h2f, 8'h3c,
        8'h3b, 8'hd4, 8'hd5, 8'h94, 8'hd0, 8'hc4, 8'h63, 8'h62,
        8'h71, 8'ha1, 8'hf9, 8'h4f, 8'h2e, 8'haa, 8'hc5, 8'h56,
        8'he3, 8'h39, 8'h93, 8'hce, 8'h65, 8'h64, 8'he4, 8'h58,
        8'h6c, 8'h19, 8'h42, 8'h79, 8'hdd, 8'hee, 8'h96, 8'hf6,
        8'h8a, 8'hec, 8'h1e, 8'h85, 8'h53, 8'h45, 8'hde, 8'hbb,
        8'h7e, 8'h0a, 8'h9a, 8'h13, 8'h2a, 8'h9d, 8'hc2, 8'h5e,
        8'h5a, 8'h1f, 8'h32, 8'h35, 8'h9c, 8'ha8, 8'h73, 8'h30,
        8'h29, 8'h3d, 8'he7, 8'h92, 8'h87, 8'h1b, 8'h2b, 8'h4b,
        8'ha5, 8'h57, 8'h97, 8'h40, 8'h15, 8'he6, 8'hbc, 8'h0e,
        8'heb, 8'hc3, 8'h34, 8'h2d, 8'hb8, 8'h44, 8'h25, 8'ha4,
        8'h1c, 8'hc7, 8'h23, 8'hed, 8'h90, 8'h6e, 8'h50, 8'h00,
        8'h99, 8'h9e, 8'h4d, 8'hd9, 8'hda, 8'h8d, 8'h6f, 8'h5f,
        8'h3e, 8'hd7, 8'h21, 8'h74, 8'h86, 8'hdf, 8'h6b, 8'h05,
        8'h8e, 8'h5d, 8'h37, 8'h11, 8'hd2, 8'h28, 8'h75, 8'hd6,
        8'ha7, 8'h77, 8'h24, 8'hbf, 8'hf0, 8'hb0, 8'h02, 8'hb7,
        8'hf8, 8'hfc, 8'h81, 8'h09, 8'hb1, 8'h01, 8'h76, 8'h91,
        8'h7d, 8'h0f, 8'hc8, 8'ha0, 8'hf2, 8'hcb, 8'h78, 8'h60,
        8'hd1, 8'hf7, 8'he0, 8'hb5, 8'h98, 8'h22, 8'hb3, 8'h20,
        8'h1d, 8'ha6, 8'hdb, 8'h7b, 8'h59, 8'h9f, 8'hae, 8'h31,
        8'hfb, 8'hd3, 8'hb6, 8'hca, 8'h43, 8'h72, 8'h07, 8'hf4,
        8'hd8, 8'h41, 8'h14, 8'h55, 8'h0d, 8'h54, 8'h8b, 8'hb9,
        8'had, 8'h46, 8'h0b, 8'haf, 8'h80, 8'h52, 8'h2c, 8'hfa,
        8'h8c, 8'h89, 8'h66, 8'hfd, 8'hb2, 8'ha9, 8'h9b, 8'hc0
    };

    assign s = SBOX[idx];

endmodule

// File: rtl/block_decrypt.sv
// CSA block decipher: one round per clock over 56 rounds, key bytes consumed
// from kk[55] down to kk[0]. Valid/ready handshake on both sides.
module block_decrypt
    import block_decrypt_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic [447:0] kk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data
);

    state_t      state, state_next;
    logic [5:0]  r, r_next;
    logic [63:0] w, w_next;

    logic [7:0]  sbox_in;
    logic [7:0]  s;
    logic [7:0]  l;
    logic [63:0] w_round;

    // Round datapath: depends only on kk, W and r.
    always_comb begin
        sbox_in = csa_byte(kk, r) ^ csa_byte({384'd0, w}, 6'd6);
    end

    block_sbox u_sbox (
        .idx (sbox_in),
        .s   (s)
    );

    // One decipher round; bytes listed W7 down to W0.
    always_comb begin
        l       = csa_byte({384'd0, w}, 6'd7) ^ s;
        w_round = {
            csa_byte({384'd0, w}, 6'd6),
            csa_byte({384'd0, w}, 6'd5) ^ csa_perm(s),
            csa_byte({384'd0, w}, 6'd4),
            csa_byte({384'd0, w}, 6'd3) ^ l,
            csa_byte({384'd0, w}, 6'd2) ^ l,
            csa_byte({384'd0, w}, 6'd1) ^ l,
            csa_byte({384'd0, w}, 6'd0),
            l
        };
    end

    // Next-state logic and Moore handshake outputs.
    always_comb begin
        state_next = state;
        r_next     = r;
        w_next     = w;
        in_ready   = (state == StIdle);
        out_valid  = (state == StDone);
        unique case (state)
            StIdle: begin
                if (in_valid) begin
                    w_next     = in_data;
                    r_next     = 6'(CSA_ROUNDS - 1);
                    state_next = StRun;
                end
            end
            StRun: begin
                w_next = w_round;
                // r stops at 0 rather than wrapping to 63
                if (r == 6'd0) begin
                    state_next = StDone;
                end else begin
                    r_next = r - 6'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_next = StIdle;
                end
            end
            default: begin
                state_next = StIdle;
            end
        endcase
    end

    // State, round counter and block register; reset discards any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            r     <= 6'd0;
            w     <= 64'd0;
        end else begin
            state <= state_next;
            r     <= r_next;
            w     <= w_next;
        end
    end

    assign out_data = w;

endmodule

// File: tb/tb_block_decrypt.sv
// Self-checking bench for block_decrypt against a byte-array reference model.
module tb_block_decrypt;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic [447:0] kk;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;

    int errors = 0;
    int checks = 0;

    logic [7:0] key_bytes [56];

    logic [7:0] SBOX [256] = '{
        8'h3a, 8'hea, 8'h68, 8'hfe, 8'h33, 8'he9, 8'h88, 8'h1a,
        8'h83, 8'hcf, 8'he1, 8'h7f, 8'hba, 8'he2, 8'h38, 8'h12,
        8'he8, 8'h27, 8'h61, 8'h95, 8'h0c, 8'h36, 8'he5, 8'h70,
        8'ha2, 8'h06, 8'h82, 8'h7c, 8'h17, 8'ha3, 8'h26, 8'h49,
        8'hbe, 8'h7a, 8'h6d, 8'h47, 8'hc1, 8'h51, 8'h8f, 8'hf3,
        8'hcc, 8'h5b, 8'h67, 8'hbd, 8'hcd, 8'h18, 8'h08, 8'hc9,
        8'hff, 8'h69, 8'hef, 8'h03, 8'h4e, 8'h48, 8'h4a, 8'h84,
        8'h3f, 8'hb4, 8'h10, 8'h04, 8'hdc, 8'hf5, 8'h5c, 8'hc6,
        8'h16, 8'hab, 8'hac, 8'h4c, 8'hf1, 8'h6a, 8'h2f, 8'h3c,
        8'h3b, 8'hd4, 8'hd5, 8'h94, 8'hd0, 8'hc4, 8'h63, 8'h62,
        8'h71, 8'ha1, 8'hf9, 8'h4f, 8'h2e, 8'haa, 8'hc5, 8'h56,
        8'he3, 8'h39, 8'h93, 8'hce, 8'h65, 8'h64, 8'he4, 8'h58,
        8'h6c, 8'h19, 8'h42, 8'h79, 8'hdd, 8'hee, 8'h96, 8'hf6,
        8'h8a, 8'hec, 8'h1e, 8'h85, 8'h53, 8'h45, 8'hde, 8'hbb,
        8'h7e, 8'h0a, 8'h9a, 8'h13, 8'h2a, 8'h9d, 8'hc2, 8'h5e,
        8'h5a, 8'h1f, 8'h32, 8'h35, 8'h9c, 8'ha8, 8'h73, 8'h30,
        8'h29, 8'h3d, 8'he7, 8'h92, 8'h87, 8'h1b, 8'h2b, 8'h4b,
        8'ha5, 8'h57, 8'h97, 8'h40, 8'h15, 8'he6, 8'hbc, 8'h0e,
        8'heb, 8'hc3, 8'h34, 8'h2d, 8'hb8, 8'h44, 8'h25, 8'ha4,
        8'h1c, 8'hc7, 8'h23, 8'hed, 8'h90, 8'h6e, 8'h50, 8'h00,
        8'h99, 8'h9e, 8'h4d, 8'hd9, 8'hda, 8'h8d, 8'h6f, 8'h5f,
        8'h3e, 8'hd7, 8'h21, 8'h74, 8'h86, 8'hdf, 8'h6b, 8'h05,
        8'h8e, 8'h5d, 8'h37, 8'h11, 8'hd2, 8'h28, 8'h75, 8'hd6,
        8'ha7, 8'h77, 8'h24, 8'hbf, 8'hf0, 8'hb0, 8'h02, 8'hb7,
        8'hf8, 8'hfc, 8'h81, 8'h09, 8'hb1, 8'h01, 8'h76, 8'h91,
        8'h7d, 8'h0f, 8'hc8, 8'ha0, 8'hf2, 8'hcb, 8'h78, 8'h60,
        8'hd1, 8'hf7, 8'he0, 8'hb5, 8'h98, 8'h22, 8'hb3, 8'h20,
        8'h1d, 8'ha6, 8'hdb, 8'h7b, 8'h59, 8'h9f, 8'hae, 8'h31,
        8'hfb, 8'hd3, 8'hb6, 8'hca, 8'h43, 8'h72, 8'h07, 8'hf4,
        8'hd8, 8'h41, 8'h14, 8'h55, 8'h0d, 8'h54, 8'h8b, 8'hb9,
        8'had, 8'h46, 8'h0b, 8'haf, 8'h80, 8'h52, 8'h2c, 8'hfa,
        8'h8c, 8'h89, 8'h66, 8'hfd, 8'hb2, 8'ha9, 8'h9b, 8'hc0
    };

    // Destination bit of the S-box output permutation for source bit b.
    int PERM_DST [8] = '{1, 7, 5, 4, 2, 3, 0, 6};

    // Key-schedule bit permutation (1-based destination positions).
    int KEY_PERM [64] = '{
        18, 36,  9,  7, 42, 49, 29, 21, 28, 54, 62, 50, 19, 33, 59, 64,
        24, 20, 37, 39,  2, 53, 27,  1, 34,  4, 13, 14, 57, 40, 26, 41,
        51, 35, 52, 12, 22, 48, 30, 58, 45, 31,  8, 25, 23, 47, 61, 17,
        60,  5, 56, 43, 11,  6, 10, 44, 32, 63, 46, 15,  3, 38, 16, 55
    };

    block_decrypt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .kk        (kk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_kk();
        for (int i = 0; i < 56; i++) kk[8*i +: 8] = key_bytes[i];
    endtask

    task automatic random_key();
        for (int i = 0; i < 56; i++) key_bytes[i] = 8'($urandom_range(0, 255));
        load_kk();
    endtask

    // Reference key schedule: cw byte 0 is the most significant byte of the 64-bit key.
    task automatic key_schedule(input logic [63:0] key);
        logic [7:0] kb [8][8];
        int         bits [64];
        int         nb [64];
        for (int j = 0; j < 8; j++) kb[7][j] = key[63 - 8*j -: 8];
        for (int i = 6; i >= 0; i--) begin
            for (int j = 0; j < 8; j++)
                for (int k = 0; k < 8; k++) begin
                    bits[j*8 + k] = int'(kb[i+1][j][7-k]);
                    nb[KEY_PERM[j*8 + k] - 1] = bits[j*8 + k];
                end
            for (int j = 0; j < 8; j++) begin
                kb[i][j] = 8'd0;
                for (int k = 0; k < 8; k++) kb[i][j][7-k] = nb[j*8 + k][0];
            end
        end
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 8; j++) key_bytes[i*8 + j] = kb[i][j] ^ 8'(i);
        load_kk();
    endtask

    // Reference decipher over a byte array, key bytes taken 55 down to 0.
    function automatic logic [63:0] ref_decrypt(input logic [63:0] ct);
        logic [7:0]  w [8];
        logic [7:0]  sv, lv, pv;
        logic [63:0] res;
        for (int j = 0; j < 8; j++) w[j] = ct[8*j +: 8];
        for (int i = 55; i >= 0; i--) begin
            sv = SBOX[key_bytes[i] ^ w[6]];
            lv = w[7] ^ sv;
            pv = 8'd0;
            for (int b = 0; b < 8; b++) pv[PERM_DST[b]] = sv[b];
            w[7] = w[6];
            w[6] = w[5] ^ pv;
            w[5] = w[4];
            w[4] = w[3] ^ lv;
            w[3] = w[2] ^ lv;
            w[2] = w[1] ^ lv;
            w[1] = w[0];
            w[0] = lv;
        end
        for (int j = 0; j < 8; j++) res[8*j +: 8] = w[j];
        return res;
    endfunction

    // Offer a block (DUT must be idle) and wait, bounded, for out_valid.
    task automatic start_block(input logic [63:0] ct, output int lat, output bit rdy_low);
        in_data  = ct;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 0;
        rdy_low  = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_block(input logic [63:0] ct, input string tag);
        int          lat;
        bit          rdy_low;
        logic [63:0] exp;
        exp       = ref_decrypt(ct);
        out_ready = 1'b1;
        start_block(ct, lat, rdy_low);
        chk({tag, "_latency"}, 64'(lat), 64'd56);
        chk({tag, "_ready_low"}, 64'(rdy_low), 64'd1);
        chk({tag, "_data"}, out_data, exp);
        @(posedge clk); #1;
        chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int          lat;
        bit          rdy_low;
        logic [63:0] held, exp;
        logic [63:0] ct [3];
        logic [63:0] outs [3];
        int          acc [3];
        int          nacc, nout, cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        out_ready = 1'b0;
        kk        = '0;
        for (int i = 0; i < 56; i++) key_bytes[i] = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        rst_n = 1'b1;

        // Latency with all-zero key and block
        run_block(64'd0, "zero");

        // Known-answer style block from the reference key schedule
        key_schedule(64'h0123456789ABCDEF);
        run_block(64'hFEDCBA9876543210, "kat");

        // Random keys and blocks
        for (int n = 0; n < 3; n++) begin
            random_key();
            run_block({$urandom, $urandom}, $sformatf("rand%0d", n));
        end

        // Backpressure: hold DONE for 20 cycles while offering another block
        random_key();
        held      = {$urandom, $urandom};
        exp       = ref_decrypt(held);
        out_ready = 1'b0;
        start_block(held, lat, rdy_low);
        chk("bp_latency", 64'(lat), 64'd56);
        chk("bp_data", out_data, exp);
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_data = {$urandom, $urandom};
            @(posedge clk); #1;
            chk($sformatf("bp_valid_%0d", c), 64'(out_valid), 64'd1);
            chk($sformatf("bp_hold_%0d", c), out_data, exp);
            chk($sformatf("bp_noacc_%0d", c), 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        chk("bp_release_valid", 64'(out_valid), 64'd0);

        // Reset part-way through the rounds
        random_key();
        in_data  = {$urandom, $urandom};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (25) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_data", out_data, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 64'(in_ready), 64'd1);
        random_key();
        run_block({$urandom, $urandom}, "post_rst");

        // Back-to-back blocks with both handshakes held high
        random_key();
        for (int k = 0; k < 3; k++) ct[k] = {$urandom, $urandom};
        nacc      = 0;
        nout      = 0;
        cyc       = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = ct[0];
        while (nout < 3 && cyc < 400) begin
            if (in_ready && nacc < 3) begin
                acc[nacc] = cyc;
                nacc++;
            end
            if (out_valid) begin
                outs[nout] = out_data;
                nout++;
            end
            @(posedge clk); #1;
            cyc++;
            if (nacc < 3) in_data = ct[nacc];
            else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("b2b_outputs", 64'(nout), 64'd3);
        if (nout == 3) begin
            chk("b2b_gap01", 64'(acc[1] - acc[0]), 64'd58);
            chk("b2b_gap12", 64'(acc[2] - acc[1]), 64'd58);
            for (int k = 0; k < 3; k++)
                chk($sformatf("b2b_data%0d", k), outs[k], ref_decrypt(ct[k]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
